// File: rtl/switch_calc.sv
// Switch-driven 4-bit calculator: operands are committed on rising edges of 'done', and
// the 8-bit saturated result is shown in binary and as four 7-segment digits.
module switch_calc (
  input  logic        CLK,
  input  logic        reset,
  input  logic [3:0]  num,
  input  logic        done,
  input  logic        mode,
  input  logic [1:0]  op,
  output logic [7:0]  result,
  output logic [27:0] display_seg,
  output logic [7:0]  bin,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_B = 3'd1,
    S_CALC   = 3'd2,
    S_SHOW   = 3'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  a_q, a_d, b_q, b_d;
  logic [7:0]  result_q, result_d;
  logic        neg_q, neg_d, err_q, err_d;
  logic        done_q;
  logic        done_rise;

  logic [7:0]  calc_val;
  logic        calc_neg, calc_err;
  logic [7:0]  sq;
  logic [11:0] a_wide, cube;
  logic [3:0]  quot;
  logic [7:0]  hund, tens, units;
  logic [6:0]  dig3;

  assign done_rise = done & ~done_q;

  assign sq     = {4'b0, a_q} * {4'b0, a_q};
  assign a_wide = {8'b0, a_q};
  assign cube   = a_wide * a_wide * a_wide;
  assign quot   = a_q / b_q;

  always_comb begin
    calc_val = 8'd0;
    calc_neg = 1'b0;
    calc_err = 1'b0;
    if (!mode) begin
      case (op)
        2'b00: calc_val = {4'b0, a_q} + {4'b0, b_q};
        2'b01: begin
          calc_neg = (a_q < b_q);
          calc_val = calc_neg ? {4'b0, b_q - a_q} : {4'b0, a_q - b_q};
        end
        2'b10: calc_val = {4'b0, a_q} * {4'b0, b_q};
        default: begin
          // Divide-by-zero is the only operation that flags an error.
          if (b_q == 4'd0) begin
            calc_val = 8'hFF;
            calc_err = 1'b1;
          end else begin
            calc_val = {4'b0, quot};
          end
        end
      endcase
    end else begin
      case (op)
        2'b00: calc_val = sq;
        2'b01: calc_val = (cube > 12'd255) ? 8'd255 : cube[7:0];
        2'b10: begin
          case (a_q)
            4'd0, 4'd1: calc_val = 8'd1;
            4'd2:       calc_val = 8'd2;
            4'd3:       calc_val = 8'd6;
            4'd4:       calc_val = 8'd24;
            4'd5:       calc_val = 8'd120;
            default:    calc_val = 8'd255;
          endcase
        end
        default: calc_val = a_q[3] ? 8'd255 : (8'd1 << a_q[2:0]);
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    neg_d    = neg_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_SHOW: begin
        if (done_rise) begin
          a_d     = num;
          b_d     = 4'd0;
          state_d = mode ? S_CALC : S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (done_rise) begin
          b_d     = num;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        result_d = calc_val;
        neg_d    = calc_neg;
        err_d    = calc_err;
        state_d  = S_SHOW;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      result_q <= 8'd0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      done_q   <= done;
    end
  end

  function automatic logic [6:0] seg7(input logic [7:0] d);
    case (d)
      8'd0:    seg7 = 7'h7E;
      8'd1:    seg7 = 7'h30;
      8'd2:    seg7 = 7'h6D;
      8'd3:    seg7 = 7'h79;
      8'd4:    seg7 = 7'h33;
      8'd5:    seg7 = 7'h5B;
      8'd6:    seg7 = 7'h5F;
      8'd7:    seg7 = 7'h70;
      8'd8:    seg7 = 7'h7F;
      8'd9:    seg7 = 7'h7B;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Decimal split of the registered result; leading zeros stay visible.
  assign hund  = result_q / 8'd100;
  assign tens  = (result_q / 8'd10) % 8'd10;
  assign units = result_q % 8'd10;
  assign dig3  = err_q ? 7'h4F : (neg_q ? 7'h01 : 7'h00);

  assign display_seg = {dig3, seg7(hund), seg7(tens), seg7(units)};
  assign result      = result_q;
  assign bin         = {a_q, b_q};
  assign state       = state_q;

endmodule

// File: tb/tb_switch_calc.sv
// Directed table-driven bench for switch_calc, plus hand sequences for the
// held-button and asynchronous-abort cases.
module tb_switch_calc;

  logic        CLK = 1'b0;
  logic        reset;
  logic [3:0]  num;
  logic        done;
  logic        mode;
  logic [1:0]  op;
  logic [7:0]  result;
  logic [27:0] display_seg;
  logic [7:0]  bin;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] D_BLANK = 7'h00;
  localparam logic [6:0] D_NEG   = 7'h01;
  localparam logic [6:0] D_E     = 7'h4F;
  localparam logic [27:0] RESET_SEG = {7'h00, 7'h7E, 7'h7E, 7'h7E};

  typedef struct {
    logic       mode;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp_res;
    logic [6:0] exp_d3;
  } vec_t;

  vec_t       vecs [15];
  logic [6:0] seg_tab [10];

  switch_calc dut (
    .CLK         (CLK),
    .reset       (reset),
    .num         (num),
    .done        (done),
    .mode        (mode),
    .op          (op),
    .result      (result),
    .display_seg (display_seg),
    .bin         (bin),
    .state       (state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [27:0] exp_disp(input logic [7:0] r, input logic [6:0] d3);
    int h, t, u;
    h = r / 100;
    t = (r / 10) % 10;
    u = r % 10;
    return {d3, seg_tab[h], seg_tab[t], seg_tab[u]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Commit A (and B in arithmetic mode); returns at the negedge two edges after the final commit.
  task automatic applyStimulus(input logic m, input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    @(negedge CLK);
    mode = m;
    op   = o;
    num  = a;
    done = 1'b1;
    @(negedge CLK);
    done = 1'b0;
    if (!m) begin
      @(negedge CLK);
      num  = b;
      done = 1'b1;
      @(negedge CLK);
      done = 1'b0;
    end
    @(negedge CLK);
  endtask

  initial begin
    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    vecs[0]  = '{1'b0, 2'b00, 4'd9,  4'd7,  8'd16,  D_BLANK};
    vecs[1]  = '{1'b0, 2'b01, 4'd3,  4'd5,  8'd2,   D_NEG};
    vecs[2]  = '{1'b0, 2'b10, 4'd15, 4'd15, 8'd225, D_BLANK};
    vecs[3]  = '{1'b0, 2'b11, 4'd7,  4'd0,  8'd255, D_E};
    vecs[4]  = '{1'b0, 2'b11, 4'd14, 4'd4,  8'd3,   D_BLANK};
    vecs[5]  = '{1'b1, 2'b10, 4'd5,  4'd0,  8'd120, D_BLANK};
    vecs[6]  = '{1'b1, 2'b10, 4'd6,  4'd0,  8'd255, D_BLANK};
    vecs[7]  = '{1'b1, 2'b01, 4'd6,  4'd0,  8'd216, D_BLANK};
    vecs[8]  = '{1'b1, 2'b11, 4'd7,  4'd0,  8'd128, D_BLANK};
    vecs[9]  = '{1'b1, 2'b00, 4'd15, 4'd0,  8'd225, D_BLANK};
    vecs[10] = '{1'b0, 2'b01, 4'd5,  4'd3,  8'd2,   D_BLANK};
    vecs[11] = '{1'b1, 2'b11, 4'd8,  4'd0,  8'd255, D_BLANK};
    vecs[12] = '{1'b0, 2'b00, 4'd15, 4'd15, 8'd30,  D_BLANK};
    vecs[13] = '{1'b1, 2'b10, 4'd0,  4'd0,  8'd1,   D_BLANK};
    vecs[14] = '{1'b1, 2'b01, 4'd2,  4'd0,  8'd8,   D_BLANK};

    reset = 1'b0;
    num   = 4'd0;
    done  = 1'b0;
    mode  = 1'b0;
    op    = 2'b00;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    checkOutput("reset state",   32'(state),       32'd0);
    checkOutput("reset result",  32'(result),      32'd0);
    checkOutput("reset display", 32'(display_seg), 32'(RESET_SEG));
    checkOutput("reset bin",     32'(bin),         32'd0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d state", i),   32'(state),  32'd3);
      checkOutput($sformatf("vec%0d result", i),  32'(result), 32'(vecs[i].exp_res));
      checkOutput($sformatf("vec%0d dig3", i),    32'(display_seg[27:21]), 32'(vecs[i].exp_d3));
      checkOutput($sformatf("vec%0d display", i), 32'(display_seg),
                  32'(exp_disp(vecs[i].exp_res, vecs[i].exp_d3)));
      checkOutput($sformatf("vec%0d bin", i),     32'(bin),
                  32'({vecs[i].a, (vecs[i].mode ? 4'd0 : vecs[i].b)}));
    end

    // Scientific commit: CALC one edge after the commit, SHOW on the second.
    @(negedge CLK);
    mode = 1'b1;
    op   = 2'b00;
    num  = 4'd3;
    done = 1'b1;
    @(negedge CLK);
    checkOutput("latency calc state", 32'(state), 32'd2);
    checkOutput("latency old result", 32'(result), 32'd8);
    @(negedge CLK);
    checkOutput("latency show state", 32'(state), 32'd3);
    checkOutput("latency result", 32'(result), 32'd9);
    done = 1'b0;

    // Holding done high for many cycles must commit only A.
    @(negedge CLK);
    mode = 1'b0;
    op   = 2'b00;
    num  = 4'd4;
    done = 1'b1;
    repeat (5) @(negedge CLK);
    num = 4'd9;
    repeat (5) @(negedge CLK);
    checkOutput("held done state", 32'(state), 32'd1);
    checkOutput("held done bin",   32'(bin),   32'h40);
    done = 1'b0;
    num  = 4'd2;
    repeat (3) @(negedge CLK);
    checkOutput("no-commit bin", 32'(bin), 32'h40);
    done = 1'b1;
    @(negedge CLK);
    done = 1'b0;
    @(negedge CLK);
    checkOutput("held done result", 32'(result), 32'd6);
    checkOutput("held done bin2",   32'(bin),    32'h42);

    // Asynchronous abort while waiting for B.
    @(negedge CLK);
    mode = 1'b0;
    num  = 4'd11;
    done = 1'b1;
    @(negedge CLK);
    done = 1'b0;
    checkOutput("pre-abort state", 32'(state), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("abort state",   32'(state),       32'd0);
    checkOutput("abort result",  32'(result),      32'd0);
    checkOutput("abort display", 32'(display_seg), 32'(RESET_SEG));
    checkOutput("abort bin",     32'(bin),         32'd0);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    checkOutput("post-abort state", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
